// File: rtl/forward_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// forward_ctrl_pkg
//
// Shared definitions for the EX-stage forwarding / load-use hazard unit.
//   - fwd_sel_e    : encodings driven onto the 3:1 EX operand mux selects
//   - reg_addr_t   : register address as carried inside a pipeline slot
//   - slot_t       : one in-flight instruction record {valid, regwrite,
//                    memread, dst}
//   - slot_produces: "this slot will write register r" predicate
//
// Slot destinations are held at a fixed width (DST_W). Narrower register
// address spaces (REG_AW <= DST_W) are zero-extended into it. This keeps
// the record type concrete and shareable between modules.
// -----------------------------------------------------------------------------
package forward_ctrl_pkg;

    // Widest register address any instance may use.
    localparam int DST_W = 8;

    // Pipeline slot positions, youngest first.
    localparam int SLOT_EX   = 0;
    localparam int SLOT_MEM  = 1;
    localparam int SLOT_WB   = 2;
    localparam int NUM_SLOTS = 3;

    // Number of EX source operands that get a forwarding select (rs, rt).
    localparam int NUM_SRC = 2;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,  // operand from the register file
        FWD_WB  = 2'b01,  // operand from the MEM/WB result
        FWD_MEM = 2'b10   // operand from the EX/MEM result
    } fwd_sel_e;

    typedef logic [DST_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        logic      regwrite;
        logic      memread;
        reg_addr_t dst;
    } slot_t;

    localparam int    SLOT_W      = $bits(slot_t);
    localparam slot_t SLOT_BUBBLE = '0;

    // A slot produces r when it is a real instruction that writes r, and r is
    // not the hard-wired zero register.
    function automatic logic slot_produces(input slot_t s, input reg_addr_t r);
        return s.valid & s.regwrite & (s.dst == r) & (r != '0);
    endfunction

endpackage

// File: rtl/forward_ctrl_cmp.sv
// -----------------------------------------------------------------------------
// fwd_cmp
//
// Computes the forwarding select for one EX source operand, given the two
// slots that can supply a bypassed value.
//
// Ports
//   ex_slot  [SLOT_W-1:0]  in   instruction currently in EX (its result will
//                               sit in EX/MEM when the consumer reaches EX)
//   mem_slot [SLOT_W-1:0]  in   instruction currently in MEM (result will sit
//                               in MEM/WB)
//   src      [DST_W-1:0]   in   source register of the instruction in ID
//   sel      [1:0]         out  FWD_MEM / FWD_WB / FWD_REG, never 2'b11
// -----------------------------------------------------------------------------
module fwd_cmp
    import forward_ctrl_pkg::*;
(
    input  logic [SLOT_W-1:0] ex_slot,
    input  logic [SLOT_W-1:0] mem_slot,
    input  logic [DST_W-1:0]  src,
    output logic [1:0]        sel
);

    slot_t ex_s;
    slot_t mem_s;

    assign ex_s  = ex_slot;
    assign mem_s = mem_slot;

    // The younger producer (EX) holds the most recent value of the register,
    // so it must win when both slots write the same destination.
    always_comb begin
        sel = FWD_REG;
        if (slot_produces(ex_s, src)) begin
            sel = FWD_MEM;
        end else if (slot_produces(mem_s, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// -----------------------------------------------------------------------------
// forward_ctrl
//
// Forwarding and load-use hazard controller for a classic 5-stage pipeline.
// Shadows the EX, MEM and WB pipeline slots, decides the EX operand bypass
// selects one cycle ahead (registered), and raises a combinational stall when
// the instruction in ID needs the result of a load that is still in EX.
//
// Parameters
//   REG_AW  register-address width (must not exceed forward_ctrl_pkg::DST_W)
//   CNT_W   stall-counter width
//
// Ports
//   clk_i          in   1      clock, rising edge
//   rst_i          in   1      synchronous reset, active low
//   id_valid_i     in   1      ID holds a real instruction
//   id_rs_i        in   REG_AW ID source register A
//   id_rt_i        in   REG_AW ID source register B
//   id_rd_i        in   REG_AW ID destination register
//   id_regwrite_i  in   1      ID instruction writes a register
//   id_memread_i   in   1      ID instruction is a load
//   flush_i        in   1      kill the instruction in ID
//   fwd_a_sel_o    out  2      registered operand-A mux select
//   fwd_b_sel_o    out  2      registered operand-B mux select
//   stall_o        out  1      load-use stall (hold PC and IF/ID)
//   stall_cnt_o    out  CNT_W  saturating count of stall cycles
// -----------------------------------------------------------------------------
module forward_ctrl
    import forward_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // -------------------------------------------------------------------------
    // ID-stage decode into slot format (addresses zero-extended to DST_W)
    // -------------------------------------------------------------------------
    slot_t     id_slot;
    reg_addr_t src_ext [NUM_SRC];

    always_comb begin
        id_slot                     = SLOT_BUBBLE;
        id_slot.valid               = id_valid_i;
        id_slot.regwrite            = id_regwrite_i;
        id_slot.memread             = id_memread_i;
        id_slot.dst[REG_AW-1:0]     = id_rd_i;

        src_ext[0]                  = '0;
        src_ext[0][REG_AW-1:0]      = id_rs_i;
        src_ext[1]                  = '0;
        src_ext[1][REG_AW-1:0]      = id_rt_i;
    end

    // -------------------------------------------------------------------------
    // In-flight slots: index SLOT_EX is youngest, SLOT_WB oldest
    // -------------------------------------------------------------------------
    slot_t slot_reg  [NUM_SLOTS];
    slot_t slot_next [NUM_SLOTS];
    slot_t ex_slot;
    logic  load_hazard;
    logic  issue;

    assign ex_slot = slot_reg[SLOT_EX];

    // A load in EX cannot be bypassed to the instruction right behind it: the
    // data only exists after MEM. Register 0 is excluded because it is never
    // really written. A flushed ID instruction is dead, so it cannot stall.
    always_comb begin
        load_hazard = 1'b0;
        if (ex_slot.valid && ex_slot.memread && ex_slot.regwrite &&
            (ex_slot.dst != '0) &&
            ((ex_slot.dst == src_ext[0]) || (ex_slot.dst == src_ext[1]))) begin
            load_hazard = 1'b1;
        end
    end

    assign stall_o = id_valid_i & ~flush_i & load_hazard;

    // The ID instruction moves into EX only when it is live and not held back;
    // otherwise EX receives a bubble. Flush wins because it gates the stall.
    assign issue = id_valid_i & ~flush_i & ~stall_o;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_next
            if (gi == SLOT_EX) begin : g_ex
                assign slot_next[gi] = issue ? id_slot : SLOT_BUBBLE;
            end else begin : g_older
                assign slot_next[gi] = slot_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!rst_i) begin
                slot_reg[i] <= SLOT_BUBBLE;
            end else begin
                slot_reg[i] <= slot_next[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Forwarding selects: computed against the slots that will be one stage
    // further along when the ID instruction reaches EX, then registered.
    // -------------------------------------------------------------------------
    logic [1:0] cmp_sel  [NUM_SRC];
    logic [1:0] sel_next [NUM_SRC];
    logic [1:0] sel_reg  [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_cmp u_fwd_cmp (
                .ex_slot  (slot_reg[SLOT_EX]),
                .mem_slot (slot_reg[SLOT_MEM]),
                .src      (src_ext[gi]),
                .sel      (cmp_sel[gi])
            );

            // A bubble entering EX has no operands to bypass.
            assign sel_next[gi] = issue ? cmp_sel[gi] : FWD_REG;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!rst_i) begin
                sel_reg[i] <= FWD_REG;
            end else begin
                sel_reg[i] <= sel_next[i];
            end
        end
    end

    assign fwd_a_sel_o = sel_reg[0];
    assign fwd_b_sel_o = sel_reg[1];

    // -------------------------------------------------------------------------
    // Saturating stall counter
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_o && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_forward_ctrl.sv
module tb_forward_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       id_valid;
    logic [4:0] rs, rt, rd;
    logic       rw, mr, flush;

    logic [1:0]  sa, sb, sa2, sb2;
    logic        stall, stall2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    forward_ctrl u_dut (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid),
        .id_rs_i(rs), .id_rt_i(rt), .id_rd_i(rd),
        .id_regwrite_i(rw), .id_memread_i(mr), .flush_i(flush),
        .fwd_a_sel_o(sa), .fwd_b_sel_o(sb), .stall_o(stall), .stall_cnt_o(cnt)
    );

    forward_ctrl #(.REG_AW(5), .CNT_W(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid),
        .id_rs_i(rs), .id_rt_i(rt), .id_rd_i(rd),
        .id_regwrite_i(rw), .id_memread_i(mr), .flush_i(flush),
        .fwd_a_sel_o(sa2), .fwd_b_sel_o(sb2), .stall_o(stall2), .stall_cnt_o(cnt2)
    );

    // ---------------- reference model ----------------
    // m_*[0] = instruction in EX, [1] = MEM, [2] = WB
    bit m_v [3];
    bit m_rw[3];
    bit m_mr[3];
    int m_dst[3];
    int exp_a, exp_b, exp_cnt, exp_cnt2;
    bit m_stall;

    int vectors = 0;
    int miscompares = 0;
    logic seen_stall;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_sel(input int src);
        if (src != 0 && m_v[0] && m_rw[0] && m_dst[0] == src) return 2;
        if (src != 0 && m_v[1] && m_rw[1] && m_dst[1] == src) return 1;
        return 0;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 0; m_rw[i] = 0; m_mr[i] = 0; m_dst[i] = 0;
        end
        exp_a = 0; exp_b = 0; exp_cnt = 0; exp_cnt2 = 0;
    endtask

    // One clock cycle: apply inputs at negedge, check the combinational stall,
    // advance the model at the edge, check registered outputs at next negedge.
    task automatic step(input bit v, input int a_rs, input int a_rt, input int a_rd,
                        input bit a_rw, input bit a_mr, input bit a_fl, input bit a_rst);
        bit go;
        int na, nb;
        id_valid = v; rs = 5'(a_rs); rt = 5'(a_rt); rd = 5'(a_rd);
        rw = a_rw; mr = a_mr; flush = a_fl; rst_n = a_rst;
        #1;
        m_stall = v && !a_fl && m_v[0] && m_mr[0] && m_rw[0] && m_dst[0] != 0 &&
                  (m_dst[0] == a_rs || m_dst[0] == a_rt);
        seen_stall = stall;
        chk("stall_o", stall, int'(m_stall));
        chk("stall_o_w2", stall2, int'(m_stall));
        go = v && !a_fl && !m_stall;
        na = go ? m_sel(a_rs) : 0;
        nb = go ? m_sel(a_rt) : 0;
        @(posedge clk);
        if (!a_rst) begin
            m_clear();
        end else begin
            exp_a = na; exp_b = nb;
            if (m_stall) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_rw[i] = m_rw[i-1];
                m_mr[i] = m_mr[i-1]; m_dst[i] = m_dst[i-1];
            end
            m_v[0] = go; m_rw[0] = go && a_rw; m_mr[0] = go && a_mr; m_dst[0] = go ? a_rd : 0;
        end
        @(negedge clk);
        chk("fwd_a_sel", sa, exp_a);
        chk("fwd_b_sel", sb, exp_b);
        chk("stall_cnt", cnt, exp_cnt);
        chk("fwd_a_sel_w2", sa2, exp_a);
        chk("fwd_b_sel_w2", sb2, exp_b);
        chk("stall_cnt_w2", cnt2, exp_cnt2);
    endtask

    task automatic alu(input int d, input int s, input int t);
        step(1, s, t, d, 1, 0, 0, 1);
    endtask
    task automatic lw(input int d, input int s);
        step(1, s, 0, d, 1, 1, 0, 1);
    endtask
    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask
    task automatic rst_cycle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit hold;
        int c_v, c_rs, c_rt, c_rd, c_rw, c_mr, c_fl, c_rst;
        rst_n = 0; id_valid = 0; rs = 0; rt = 0; rd = 0; rw = 0; mr = 0; flush = 0;
        m_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state
        rst_cycle();
        chk("rst_sel_a", sa, 0);
        chk("rst_cnt", cnt, 0);
        nop();
        chk("rst_no_stall", seen_stall, 0);

        // EX/MEM forward back-to-back
        alu(3, 1, 2); alu(4, 3, 1);
        chk("b2b_fwd_a", sa, 2);
        chk("b2b_no_stall", seen_stall, 0);

        // MEM/WB forward across a nop, then priority
        nop(); nop();
        alu(3, 1, 1); nop(); alu(5, 2, 3);
        chk("wb_fwd_b", sb, 1);
        nop(); nop();
        alu(3, 1, 1); alu(3, 2, 2); alu(6, 1, 3);
        chk("prio_fwd_b", sb, 2);

        // load-use: one stall, then both operands from MEM/WB
        nop(); nop();
        lw(7, 1);
        alu(8, 7, 7);
        chk("lu_stall", seen_stall, 1);
        chk("lu_cnt", cnt, 1);
        alu(8, 7, 7);
        chk("lu_stall_once", seen_stall, 0);
        chk("lu_fwd_a", sa, 1);
        chk("lu_fwd_b", sb, 1);

        // register zero never forwards or stalls
        nop(); nop();
        alu(0, 1, 2); alu(4, 0, 0);
        chk("r0_fwd_a", sa, 0);
        chk("r0_fwd_b", sb, 0);
        lw(0, 1); alu(4, 0, 0);
        chk("r0_no_stall", seen_stall, 0);

        // flush kills a load-use consumer
        nop(); nop();
        lw(7, 1);
        step(1, 7, 7, 8, 1, 0, 1, 1);
        chk("flush_no_stall", seen_stall, 0);
        chk("flush_bubble_a", sa, 0);

        // mid-stream reset discards producers
        alu(3, 1, 1); alu(4, 1, 1);
        rst_cycle();
        chk("mid_rst_cnt", cnt, 0);
        alu(5, 3, 4);
        chk("mid_rst_fwd_a", sa, 0);
        chk("mid_rst_fwd_b", sb, 0);

        // saturation of the narrow counter
        repeat (5) begin
            lw(7, 1); alu(8, 7, 7); alu(8, 7, 7);
        end
        chk("sat_cnt16", cnt, 5);
        chk("sat_cnt2", cnt2, 3);

        // randomized traffic; ID is held while stalled, as the real pipe would
        hold = 0;
        c_v = 0; c_rs = 0; c_rt = 0; c_rd = 0; c_rw = 0; c_mr = 0; c_fl = 0; c_rst = 1;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                c_v  = ($urandom_range(0, 99) < 85);
                c_rs = $urandom_range(0, 3);
                c_rt = $urandom_range(0, 3);
                c_rd = $urandom_range(0, 3);
                c_rw = ($urandom_range(0, 99) < 80);
                c_mr = ($urandom_range(0, 99) < 30);
            end
            c_fl  = ($urandom_range(0, 99) < 8);
            c_rst = ($urandom_range(0, 99) >= 2);
            step(c_v[0], c_rs, c_rt, c_rd, c_rw[0], c_mr[0], c_fl[0], c_rst[0]);
            hold = m_stall && c_rst[0];
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-low.
REQ-005 id_valid_i  input  1  ID stage holds a real instruction.
REQ-006 id_rs_i / id_rt_i  input  REG_AW  ID source registers.
REQ-007 id_rd_i  input  REG_AW  ID destination register.
REQ-008 id_regwrite_i / id_memread_i  input  1  ID writes a register / is a load.
REQ-009 flush_i  input  1  kill the instruction currently in ID (branch taken).
REQ-010 fwd_a_sel_o / fwd_b_sel_o  output  2  registered select for the 3:1 EX operand muxes: 00 register file, 01 MEM/WB result, 10 EX/MEM result.
REQ-011 stall_o  output  1  combinational load-use stall; hold PC and IF/ID.
REQ-012 stall_cnt_o  output  CNT_W  saturating count of stall cycles.

Function
REQ-013 SHALL track three in-flight slots EX, MEM, WB, each {valid, regwrite, memread, dst}.
REQ-014 Per cycle without stall/flush: EX<-ID fields, MEM<-EX, WB<-MEM.
REQ-015 On stall_o=1: EX<-bubble (valid=0), MEM<-EX, WB<-MEM.
REQ-016 On flush_i=1: EX<-bubble, MEM<-EX, WB<-MEM; flush overrides stall.
REQ-017 A slot "produces r" iff valid & regwrite & dst==r & r!=0.
REQ-018 Next fwd_a_sel = 10 if current EX slot produces id_rs_i, else 01 if current MEM slot produces id_rs_i, else 00; fwd_b_sel identical with id_rt_i.
REQ-019 EX/MEM match SHALL take priority over MEM/WB match when both hit.
REQ-020 Selects SHALL be registered, valid the cycle the instruction occupies EX (latency 1 from ID).
REQ-021 Value 11 SHALL never be driven on either select.
REQ-022 When the EX slot is loaded with a bubble (stall, flush, id_valid_i=0) both selects SHALL load 00.
REQ-023 stall_o = id_valid_i & ~flush_i & EX.valid & EX.memread & EX.regwrite & EX.dst!=0 & (EX.dst==id_rs_i | EX.dst==id_rt_i).
REQ-024 stall_o SHALL assert for exactly one cycle per load-use pair; after the bubble the dependent instruction gets select 01.
REQ-025 stall_cnt_o SHALL increment on each cycle stall_o=1 and saturate at all-ones.
REQ-026 Register 0 as destination or source SHALL never cause forwarding or stall.

Reset
REQ-027 While rst_i=0 at a rising edge: all slots invalid, both selects 00, stall_cnt_o 0; stall_o therefore 0 next cycle.
REQ-028 Reset mid-stream SHALL discard all in-flight slots; no forwarding from pre-reset instructions.

Structure
REQ-029 Shared package SHALL hold select encodings FWD_REG=00, FWD_WB=01, FWD_MEM=10 and the slot record type.
REQ-030 One sub-module fwd_cmp SHALL compute the 2-bit select for one source operand from two slots.
REQ-031 Output selects SHALL connect directly to the existing 3:1 operand mux select ports.

Verification
REQ-032 add $3 then add $4,$3,$1 back-to-back -> fwd_a_sel_o=10 in consumer EX cycle, stall_o=0.
REQ-033 add $3; nop; sub $5,$2,$3 -> fwd_b_sel_o=01; with add $3 in both EX and MEM slots -> 10 (priority).
REQ-034 lw $7 then add $8,$7,$7 -> stall_o=1 one cycle, stall_cnt_o 0->1, consumer EX selects both 01.
REQ-035 add $0,... then use $0 -> selects 00, no stall; flush_i with lw/use pair in ID -> stall_o=0, EX bubble.
REQ-036 rst_i=0 for one edge with producers in EX/MEM -> next consumer selects 00, stall_cnt_o=0; CNT_W=2 with 5 stalls -> stall_cnt_o=3.
